mem_access_delay_fifo: RTL and testbench

Parametrised, time-tagged memory-access FIFO for the SIMD memory system. Each entry records a RAM bank address, a full request address, an issue timestamp and a release timestamp (issue + delay). The head entry is offered to the consumer only once the free-running cycle count reaches its release time. This models fixed per-request memory latency with proper full/empty/occupancy tracking.

---
 rtl/mem_access_delay_fifo.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_delay_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_delay_fifo.sv
// -----------------------------------------------------------------------------
// mem_access_delay_fifo
//
// Time-tagged FIFO that models a fixed per-request memory latency. Each entry
// holds a RAM bank address, the full request address, the issue timestamp and
// the release timestamp (issue + delay). The head entry is offered to the
// consumer only once the free-running cycle count has reached its release time.
//
// Optional feature macro: MEM_FIFO_DROP_CNT_EN
//   defined   -> drop_cnt_o counts pushes rejected because the FIFO was full
//                (saturating, cleared only by reset)
//   undefined -> drop_cnt_o is tied to 0
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous, active-high reset
//   stall_i          in   pipeline stall; freezes pointers, occupancy, counter
//   push_i           in   push request
//   ram_addr_i       in   bank address to store
//   addr_i           in   request address to store
//   delay_i          in   latency for this request (zero-extended)
//   count_i          in   free-running, wrapping cycle count
//   pop_i            in   consumer accepts head
//   valid_o          out  head present and due
//   ram_addr_o       out  head bank address (0 while empty)
//   addr_o           out  head request address (0 while empty)
//   head_in_time_o   out  head issue timestamp (0 while empty)
//   head_out_time_o  out  head release timestamp (0 while empty)
//   num_o            out  occupancy, 0..DEPTH
//   full_o           out  num_o == DEPTH
//   empty_o          out  num_o == 0
//   drop_cnt_o       out  rejected-push counter
// -----------------------------------------------------------------------------
module mem_access_delay_fifo #(
    parameter int DEPTH      = 32,
    parameter int DEPTH_LOG  = 5,
    parameter int RAM_ADDR_W = 5,
    parameter int ADDR_W     = 32,
    parameter int COUNT_W    = 16,
    parameter int DELAY_W    = 10,
    parameter int DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  push_i,
    input  logic [RAM_ADDR_W-1:0] ram_addr_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DELAY_W-1:0]    delay_i,
    input  logic [COUNT_W-1:0]    count_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [COUNT_W-1:0]    head_in_time_o,
    output logic [COUNT_W-1:0]    head_out_time_o,
    output logic [DEPTH_LOG:0]    num_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DROP_W-1:0]     drop_cnt_o
);

    localparam logic [DEPTH_LOG:0]   NUM_FULL = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   NUM_ONE  = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG-1:0] PTR_ONE  = {{(DEPTH_LOG-1){1'b0}}, 1'b1};

    // Entry storage, one array per field
    logic [RAM_ADDR_W-1:0] ram_addr_mem [DEPTH];
    logic [ADDR_W-1:0]     addr_mem     [DEPTH];
    logic [COUNT_W-1:0]    in_time_mem  [DEPTH];
    logic [COUNT_W-1:0]    out_time_mem [DEPTH];

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   num_q,  num_d;

    logic                 full_w;
    logic                 empty_w;
    logic                 push_acc;
    logic                 pop_acc;
    logic                 due;
    logic                 valid_w;
    logic [COUNT_W-1:0]   due_diff;
    logic [COUNT_W-1:0]   out_time_new;

    // Status decoded from the registered occupancy, i.e. before this cycle's pop,
    // so a push while full is rejected even when a pop is accepted alongside it.
    assign full_w   = (num_q == NUM_FULL);
    assign empty_w  = (num_q == '0);
    assign push_acc = push_i & ~full_w & ~stall_i;

    // Wrap-safe due test: the head is due once (count - release) is
    // non-negative when read as a two's-complement number.
    assign due_diff = count_i - out_time_mem[head_q];
    assign due      = ~due_diff[COUNT_W-1];
    assign valid_w  = ~empty_w & due;
    assign pop_acc  = pop_i & valid_w & ~stall_i;

    assign out_time_new = count_i + {{(COUNT_W-DELAY_W){1'b0}}, delay_i};

    // NOTE: every signal written here is given its hold value first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        num_d  = num_q;
        if (push_acc) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (pop_acc) begin
            head_d = head_q + PTR_ONE;
        end
        case ({push_acc, pop_acc})
            2'b10:   num_d = num_q + NUM_ONE;
            2'b01:   num_d = num_q - NUM_ONE;
            default: num_d = num_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            num_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            num_q  <= num_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; a cleared num_q makes
    // stale contents unreachable, and leaving it out keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            ram_addr_mem[tail_q] <= ram_addr_i;
            addr_mem[tail_q]     <= addr_i;
            in_time_mem[tail_q]  <= count_i;
            out_time_mem[tail_q] <= out_time_new;
        end
    end

`ifdef MEM_FIFO_DROP_CNT_EN
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [DROP_W-1:0] drop_q, drop_d;

    // Counts every push request seen while full (stall excepted), saturating.
    always_comb begin
        drop_d = drop_q;
        if (push_i && full_w && !stall_i && (drop_q != '1)) begin
            drop_d = drop_q + DROP_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    assign drop_cnt_o = '0;
`endif

    // Head outputs read the storage asynchronously and are masked while empty.
    assign valid_o         = valid_w;
    assign ram_addr_o      = empty_w ? '0 : ram_addr_mem[head_q];
    assign addr_o          = empty_w ? '0 : addr_mem[head_q];
    assign head_in_time_o  = empty_w ? '0 : in_time_mem[head_q];
    assign head_out_time_o = empty_w ? '0 : out_time_mem[head_q];
    assign num_o           = num_q;
    assign full_o          = full_w;
    assign empty_o         = empty_w;

endmodule

// File: tb/tb_mem_access_delay_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_delay_fifo.
// Directed stimulus pushes hand-computed expected entries into a scoreboard
// queue; a monitor pops and compares whenever the DUT accepts a pop.
// -----------------------------------------------------------------------------
module tb_mem_access_delay_fifo;

    typedef struct packed {
        logic [4:0]  ram;
        logic [31:0] addr;
        logic [15:0] tin;
        logic [15:0] tout;
    } exp_t;

`ifdef MEM_FIFO_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        push_i;
    logic [4:0]  ram_addr_i;
    logic [31:0] addr_i;
    logic [9:0]  delay_i;
    logic [15:0] count_i;
    logic        pop_i;
    logic        valid_o;
    logic [4:0]  ram_addr_o;
    logic [31:0] addr_o;
    logic [15:0] head_in_time_o;
    logic [15:0] head_out_time_o;
    logic [5:0]  num_o;
    logic        full_o;
    logic        empty_o;
    logic [15:0] drop_cnt_o;

    int   vectors;
    int   miscompares;
    exp_t sb[$];
    exp_t mon_e;

    mem_access_delay_fifo dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .push_i          (push_i),
        .ram_addr_i      (ram_addr_i),
        .addr_i          (addr_i),
        .delay_i         (delay_i),
        .count_i         (count_i),
        .pop_i           (pop_i),
        .valid_o         (valid_o),
        .ram_addr_o      (ram_addr_o),
        .addr_o          (addr_o),
        .head_in_time_o  (head_in_time_o),
        .head_out_time_o (head_out_time_o),
        .num_o           (num_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; the cycle count moves on by one.
    task automatic step();
        @(posedge clk);
        #1;
        count_i = count_i + 16'd1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Drive a push for this cycle and record the entry the DUT should store.
    task automatic drive_push(input logic [4:0] ram, input logic [31:0] addr,
                              input logic [9:0] dly, input bit expect_store);
        exp_t e;
        push_i     = 1'b1;
        ram_addr_i = ram;
        addr_i     = addr;
        delay_i    = dly;
        if (expect_store) begin
            e.ram  = ram;
            e.addr = addr;
            e.tin  = count_i;
            e.tout = count_i + {6'd0, dly};
            sb.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    valid_o,         64'd0);
        check({tag, "_empty"},    empty_o,         64'd1);
        check({tag, "_full"},     full_o,          64'd0);
        check({tag, "_num"},      num_o,           64'd0);
        check({tag, "_drop"},     drop_cnt_o,      64'd0);
        check({tag, "_ram_addr"}, ram_addr_o,      64'd0);
        check({tag, "_addr"},     addr_o,          64'd0);
        check({tag, "_in_time"},  head_in_time_o,  64'd0);
        check({tag, "_out_time"}, head_out_time_o, 64'd0);
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && valid_o && pop_i && !stall_i) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got addr 0x%0h, expected no entry", addr_o);
            end else begin
                mon_e = sb.pop_front();
                check("head_ram_addr", ram_addr_o,      mon_e.ram);
                check("head_addr",     addr_o,          mon_e.addr);
                check("head_in_time",  head_in_time_o,  mon_e.tin);
                check("head_out_time", head_out_time_o, mon_e.tout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        stall_i     = 1'b0;
        push_i      = 1'b0;
        pop_i       = 1'b0;
        ram_addr_i  = '0;
        addr_i      = '0;
        delay_i     = '0;
        count_i     = '0;

        // Reset state
        #12;
        check_reset_outputs("rst");
        step();
        reset = 1'b0;
        sample();

        // Basic push at count 10 with delay 4
        step();
        count_i = 16'd10;
        drive_push(5'd3, 32'h0000_1000, 10'd4, 1'b1);
        sample();
        step();
        push_i = 1'b0;
        sample();
        check("basic_empty",    empty_o,         64'd0);
        check("basic_num",      num_o,           64'd1);
        check("basic_out_time", head_out_time_o, 64'd14);
        check("basic_valid11",  valid_o,         64'd0);
        step();
        sample();
        check("basic_valid12", valid_o, 64'd0);
        step();
        sample();
        check("basic_valid13", valid_o, 64'd0);
        step();
        pop_i = 1'b1;
        sample();
        check("basic_valid14", valid_o, 64'd1);
        step();
        pop_i = 1'b0;
        sample();
        check("basic_pop_empty", empty_o,         64'd1);
        check("basic_pop_num",   num_o,           64'd0);
        check("basic_pop_ram",   ram_addr_o,      64'd0);
        check("basic_pop_addr",  addr_o,          64'd0);
        check("basic_pop_in",    head_in_time_o,  64'd0);
        check("basic_pop_out",   head_out_time_o, 64'd0);

        // Release-time wrap
        step();
        count_i = 16'hFFFE;
        drive_push(5'd7, 32'hDEAD_BEEF, 10'd5, 1'b1);
        sample();
        step();
        push_i = 1'b0;
        sample();
        check("wrap_out_time", head_out_time_o, 64'h0003);
        check("wrap_valid_ffff", valid_o, 64'd0);
        step();
        sample();
        check("wrap_valid_0000", valid_o, 64'd0);
        step();
        step();
        sample();
        check("wrap_valid_0002", valid_o, 64'd0);
        step();
        pop_i = 1'b1;
        sample();
        check("wrap_valid_0003", valid_o, 64'd1);
        step();
        pop_i = 1'b0;
        sample();
        check("wrap_pop_empty", empty_o, 64'd1);

        // Fill to 32 entries
        for (int i = 0; i < 32; i++) begin
            step();
            drive_push(5'(i), 32'h0000_2000 + 32'(i), 10'd0, 1'b1);
            sample();
        end
        step();
        push_i = 1'b0;
        sample();
        check("fill_full", full_o, 64'd1);
        check("fill_num",  num_o,  64'd32);

        // 33rd push is rejected
        step();
        drive_push(5'd31, 32'hBAD0_0033, 10'd0, 1'b0);
        sample();
        step();
        push_i = 1'b0;
        sample();
        check("full_rej_num",  num_o,      64'd32);
        check("full_rej_drop", drop_cnt_o, DROP_EN ? 64'd1 : 64'd0);

        // Push + pop while full: pop accepted, push still rejected
        step();
        drive_push(5'd30, 32'hBAD0_0034, 10'd0, 1'b0);
        pop_i = 1'b1;
        sample();
        step();
        push_i = 1'b0;
        pop_i  = 1'b0;
        sample();
        check("full_pp_num",  num_o,      64'd31);
        check("full_pp_full", full_o,     64'd0);
        check("full_pp_drop", drop_cnt_o, DROP_EN ? 64'd2 : 64'd0);

        // Drain down to 5 entries
        for (int i = 0; i < 26; i++) begin
            step();
            pop_i = 1'b1;
            sample();
        end
        step();
        pop_i = 1'b0;
        sample();
        check("drain_num", num_o, 64'd5);

        // Simultaneous push + pop, 40 cycles across pointer wrap
        for (int i = 0; i < 40; i++) begin
            step();
            drive_push(5'(i + 9), 32'h0000_3000 + 32'(i), 10'd0, 1'b1);
            pop_i = 1'b1;
            sample();
            check("pp_valid", valid_o, 64'd1);
        end
        step();
        push_i = 1'b0;
        pop_i  = 1'b0;
        sample();
        check("pp_num", num_o, 64'd5);

        // Stall with push and pop requested freezes all state
        for (int i = 0; i < 3; i++) begin
            step();
            stall_i = 1'b1;
            drive_push(5'd2, 32'hBAD0_5000, 10'd0, 1'b0);
            pop_i = 1'b1;
            sample();
            check("stall_num",   num_o,   64'd5);
            check("stall_valid", valid_o, 64'd1);
        end
        step();
        stall_i = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        sample();
        check("stall_after_num",  num_o,      64'd5);
        check("stall_after_drop", drop_cnt_o, DROP_EN ? 64'd2 : 64'd0);

        // Grow to 7 entries, then pop one to show head unchanged by the stall
        for (int i = 0; i < 3; i++) begin
            step();
            drive_push(5'(20 + i), 32'h0000_4000 + 32'(i), 10'd100, 1'b1);
            sample();
        end
        step();
        push_i = 1'b0;
        pop_i  = 1'b1;
        sample();
        step();
        pop_i = 1'b0;
        sample();
        check("pre_rst_num", num_o, 64'd7);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        step();
        reset = 1'b0;
        sample();
        check("post_rst_num",   num_o,   64'd0);
        check("post_rst_empty", empty_o, 64'd1);

        // Normal operation after reset
        step();
        drive_push(5'h1F, 32'hCAFE_0000, 10'd1, 1'b1);
        sample();
        step();
        push_i = 1'b0;
        sample();
        check("post_rst_push_num",   num_o,   64'd1);
        check("post_rst_push_valid", valid_o, 64'd1);
        step();
        pop_i = 1'b1;
        sample();
        step();
        pop_i = 1'b0;
        sample();
        check("post_rst_pop_empty", empty_o, 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
